barrel_shifter: RTL and testbench

- Registered barrel shifter used as the shift unit of the RV32 ALU.
- Implements the SRL, SLL and SRA shift instructions, plus their immediate forms.
- The ALU drives type from alufn[1:0] and shamt from operand b[4:0].
- Result is registered once, so latency is one cycle; the ALU shift path must account for it.

---
 rtl/barrel_shifter.sv | 96 +++++++++
 tb/tb_barrel_shifter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/barrel_shifter.sv
// Registered barrel shifter for the RV32 ALU: SRL/SLL/SRA, one-cycle latency.
// Optional SHIFTER_ROTATE_EN macro makes op_type=11 a rotate-right; otherwise it passes a through.
module barrel_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op_type,
  output logic               out_valid,
  output logic [WIDTH-1:0]   r
);

  typedef enum logic [1:0] {
    OpSrl = 2'b00,
    OpSll = 2'b01,
    OpSra = 2'b10,
    OpAlt = 2'b11
  } op_e;

  op_e op;
  logic is_left, is_rot, fill_bit;
  logic [WIDTH-1:0] stage_in, cur, nxt, result;
  logic [SHAMT_W-1:0] src;

  assign op = op_e'(op_type);

  always_comb begin
    is_left  = (op == OpSll);
    fill_bit = (op == OpSra) ? a[WIDTH-1] : 1'b0;
`ifdef SHIFTER_ROTATE_EN
    is_rot   = (op == OpAlt);
`else
    is_rot   = 1'b0;
`endif
  end

  // Left shifts reuse the right-shift stages on the bit-reversed operand.
  always_comb begin
    stage_in = '0;
    for (int i = 0; i < WIDTH; i++) begin
      stage_in[i] = is_left ? a[WIDTH-1-i] : a[i];
    end
  end

  // Stage k shifts right by 2^k when shamt[k] is set; wrap-in bits come from the low end.
  always_comb begin
    cur = stage_in;
    nxt = stage_in;
    src = '0;
    for (int k = 0; k < SHAMT_W; k++) begin
      nxt = cur;
      if (shamt[k]) begin
        for (int i = 0; i < WIDTH; i++) begin
          src = SHAMT_W'(i + (1 << k));
          if ((i + (1 << k)) < WIDTH || is_rot) begin
            nxt[i] = cur[src];
          end else begin
            nxt[i] = fill_bit;
          end
        end
      end
      cur = nxt;
    end
  end

  always_comb begin
    result = cur;
    if (is_left) begin
      for (int i = 0; i < WIDTH; i++) begin
        result[i] = cur[WIDTH-1-i];
      end
    end
`ifndef SHIFTER_ROTATE_EN
    if (op == OpAlt) begin
      result = a;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        r <= result;
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: directed boundary cases plus random
// operations checked against an arithmetic reference model.
module tb_barrel_shifter;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         op_type;
  logic               out_valid;
  logic [WIDTH-1:0]   r;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_r = '0;
  logic             exp_v = 1'b0;

  barrel_shifter #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .shamt    (shamt),
    .op_type  (op_type),
    .out_valid(out_valid),
    .r        (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] aa,
                                             input logic [SHAMT_W-1:0] sh,
                                             input logic [1:0] t);
    logic signed [WIDTH-1:0] sa;
    int n;
    sa = aa;
    n  = int'(sh);
    case (t)
      2'b00:   return aa >> n;
      2'b01:   return aa << n;
      2'b10:   return WIDTH'(sa >>> n);
`ifdef SHIFTER_ROTATE_EN
      default: return (aa >> n) | (aa << (WIDTH - n));
`else
      default: return aa;
`endif
    endcase
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  // Drive one cycle, advance the model, then compare just after the edge.
  task automatic cycle(input logic rr, input logic v, input logic [WIDTH-1:0] aa,
                       input logic [SHAMT_W-1:0] sh, input logic [1:0] t, input string tag);
    rst      = rr;
    in_valid = v;
    a        = aa;
    shamt    = sh;
    op_type  = t;
    @(posedge clk);
    #1;
    if (rr) begin
      exp_r = '0;
      exp_v = 1'b0;
    end else begin
      exp_v = v;
      if (v) exp_r = model(aa, sh, t);
    end
    check({tag, "_r"}, r, exp_r);
    check({tag, "_v"}, {31'b0, out_valid}, {31'b0, exp_v});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 32'hFFFF_FFFF; shamt = '0; op_type = 2'b00;

    cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd0, 2'b00, "rst0");
    cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd3, 2'b01, "rst1");
    check("rst_lit", r, 32'h0);
    cycle(1'b0, 1'b0, 32'hFFFF_FFFF, 5'd0, 2'b00, "post_rst");
    check("post_rst_v_lit", {31'b0, out_valid}, 32'h0);

    cycle(1'b0, 1'b1, 32'h8000_0001, 5'd4, 2'b00, "srl4");
    check("srl4_lit", r, 32'h0800_0000);
    cycle(1'b0, 1'b1, 32'h8000_0001, 5'd4, 2'b01, "sll4");
    check("sll4_lit", r, 32'h0000_0010);
    cycle(1'b0, 1'b1, 32'h8000_0000, 5'd31, 2'b10, "sra31");
    check("sra31_lit", r, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b1, 32'h4000_0000, 5'd30, 2'b10, "sra30");
    check("sra30_lit", r, 32'h0000_0001);

    for (int t = 0; t < 3; t++) begin
      cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 5'd0, 2'(t), "zero");
      check("zero_lit", r, 32'hDEAD_BEEF);
    end

    cycle(1'b0, 1'b1, 32'h8000_0001, 5'd31, 2'b00, "srl31");
    check("srl31_lit", r, 32'h0000_0001);
    cycle(1'b0, 1'b1, 32'h8000_0001, 5'd31, 2'b01, "sll31");
    check("sll31_lit", r, 32'h8000_0000);

    cycle(1'b0, 1'b1, 32'h0000_0001, 5'd31, 2'b01, "b2b0");
    check("b2b0_lit", r, 32'h8000_0000);
    cycle(1'b0, 1'b1, 32'h0000_0001, 5'd1, 2'b00, "b2b1");
    check("b2b1_lit", r, 32'h0000_0000);
    cycle(1'b0, 1'b0, 32'h1234_5678, 5'd7, 2'b01, "idle");
    check("idle_lit", r, 32'h0000_0000);

    cycle(1'b0, 1'b1, 32'h0000_0001, 5'd1, 2'b11, "op11");
`ifdef SHIFTER_ROTATE_EN
    check("op11_lit", r, 32'h8000_0000);
`else
    check("op11_lit", r, 32'h0000_0001);
`endif

    // Reset while valid must discard the sampled operation.
    cycle(1'b1, 1'b1, 32'hCAFE_F00D, 5'd5, 2'b10, "mid_rst");
    cycle(1'b0, 1'b0, 32'h0, 5'd0, 2'b00, "mid_rst_after");

    for (int n = 0; n < 300; n++) begin
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), $urandom,
            5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
